// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared types and constants for the shared-multiplier controller
// Contents: FSM state enum, default WIDTH/MULT_LAT, requester id type and
// the 3-bit latency counter type (covers MULT_LAT 0..7).
package mult_share_pkg;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MULT_LAT = 2;
    localparam int CNT_W        = 3;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef logic id_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if: request, multiplier and response signals of the shared-multiplier controller
// master: requesters + array multiplier + response consumer
//   drives reqN_valid/reqN_a/reqN_b, mul_p, rsp_ready; observes reqN_ready, mul_a/mul_b, rsp_*
// slave: the controller, mirror image of master
interface mult_share_ctrl_if #(
    parameter int WIDTH = 8
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_p;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_p;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p, rsp_ready,
        input  req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p, rsp_ready,
        output req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mult_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter
// valid_i : request valids {req1, req0}
// ptr_i   : id of the last granted requester; the other one wins a tie
// en_i    : grants are only issued while enabled
// gnt_o   : one-hot grant {req1, req0}
// gnt_id_o: id of the requester that would be granted
module rr_arb2
    import mult_share_pkg::*;
(
    input  logic [1:0] valid_i,
    input  id_t        ptr_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output id_t        gnt_id_o
);
    always_comb begin
        gnt_id_o = (&valid_i) ? ~ptr_i : valid_i[1];
        gnt_o    = (en_i && |valid_i) ? (gnt_id_o ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one external WIDTHxWIDTH array multiplier between two requesters
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of mult_share_ctrl_if (request channels, multiplier operands/product,
//            response channel)
// busy_o   : high whenever the controller is not idle
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic             clk,
    input  logic             rst,
    mult_share_ctrl_if.slave bus,
    output logic             busy_o
);
    state_t               state_q;
    cnt_t                 cnt_q;
    id_t                  ptr_q;
    id_t                  id_q;
    id_t                  rsp_id_q;
    logic                 rsp_valid_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [2*WIDTH-1:0]   rsp_p_q;
    logic [1:0]           gnt;
    id_t                  gnt_id;

    rr_arb2 u_arb (
        .valid_i  ({bus.req1_valid, bus.req0_valid}),
        .ptr_i    (ptr_q),
        .en_i     (state_q == IDLE),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_p      = rsp_p_q;
    assign busy_o         = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= 1'b1;
            id_q        <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_p_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    mul_a_q <= gnt_id ? bus.req1_a : bus.req0_a;
                    mul_b_q <= gnt_id ? bus.req1_b : bus.req0_b;
                    id_q    <= gnt_id;
                    ptr_q   <= gnt_id;
                    cnt_q   <= CNT_W'(MULT_LAT);
                    state_q <= WAIT;
                end
                // counter reaches zero exactly in the cycle the product is valid
                WAIT: if (cnt_q == '0) begin
                    rsp_p_q     <= bus.mul_p;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: self-checking bench for mult_share_ctrl (MULT_LAT=2 and MULT_LAT=0 builds)
module tb_mult_share_ctrl;
    localparam int W  = 8;
    localparam int PW = 2 * W;
    localparam int L  = 2;

    typedef struct {
        logic          id;
        logic [PW-1:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic busy0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mult_share_ctrl_if #(.WIDTH(W)) ifa ();
    mult_share_ctrl_if #(.WIDTH(W)) ifz ();

    mult_share_ctrl #(.WIDTH(W), .MULT_LAT(L)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (ifa.slave),
        .busy_o (busy)
    );

    mult_share_ctrl #(.WIDTH(W), .MULT_LAT(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus    (ifz.slave),
        .busy_o (busy0)
    );

    // array multiplier models: L-stage registered pipeline and a purely combinational one
    logic [PW-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= PW'(ifa.mul_a) * PW'(ifa.mul_b);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ifa.mul_p = pipe[L-1];
    assign ifz.mul_p = PW'(ifz.mul_a) * PW'(ifz.mul_b);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (i == 0) begin
            ifa.req0_valid = v; ifa.req0_a = a; ifa.req0_b = b;
        end else begin
            ifa.req1_valid = v; ifa.req1_a = a; ifa.req1_b = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_req(0, 1'b0, '0, '0);
        drive_req(1, 1'b0, '0, '0);
        ifa.rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({busy, busy0, ifa.rsp_valid, ifz.rsp_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got busy=%b busy0=%b rv=%b rv0=%b want all 0", busy, busy0, ifa.rsp_valid, ifz.rsp_valid);
        end
        n_tests++;
        if ({ifa.mul_a, ifa.mul_b} !== 16'd0) begin
            n_fail++; $display("FAIL reset_mul: got a=%0d b=%0d want 0 0", ifa.mul_a, ifa.mul_b);
        end
        n_tests++;
        if (ifa.rsp_p !== '0 || ifa.rsp_id !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: got p=%0d id=%b want 0 0", ifa.rsp_p, ifa.rsp_id);
        end
        n_tests++;
        if ({ifa.req1_ready, ifa.req0_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", {ifa.req1_ready, ifa.req0_ready});
        end
    endtask

    task automatic test_single();
        drive_req(0, 1'b1, 8'd3, 8'd5);
        #1;
        n_tests++;
        if ({ifa.req1_ready, ifa.req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL single_ready: got %b want 01", {ifa.req1_ready, ifa.req0_ready});
        end
        tick();
        ifa.req0_valid = 1'b0;
        #1;
        n_tests++;
        if ({busy, ifa.mul_a, ifa.mul_b} !== {1'b1, 8'd3, 8'd5}) begin
            n_fail++; $display("FAIL single_issue: got busy=%b a=%0d b=%0d want 1 3 5", busy, ifa.mul_a, ifa.mul_b);
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            n_tests++;
            if (ifa.rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL single_early: T+%0d got rsp_valid=%b want 0", c, ifa.rsp_valid);
            end
        end
        tick();
        n_tests++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_p !== 16'd15 || ifa.rsp_id !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: got v=%b p=%0d id=%b want 1 15 0", ifa.rsp_valid, ifa.rsp_p, ifa.rsp_id);
        end
        ifa.rsp_ready = 1'b1;
        tick();
        ifa.rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (ifa.rsp_valid !== 1'b0 || busy !== 1'b0 || ifa.rsp_p !== 16'd15) begin
            n_fail++; $display("FAIL single_done: got v=%b busy=%b p=%0d want 0 0 15", ifa.rsp_valid, busy, ifa.rsp_p);
        end
    endtask

    task automatic test_tie();
        do_reset();
        drive_req(0, 1'b1, 8'd255, 8'd255);
        drive_req(1, 1'b1, 8'd16, 8'd16);
        ifa.rsp_ready = 1'b1;
        #1;
        n_tests++;
        if ({ifa.req1_ready, ifa.req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL tie_first: got %b want 01", {ifa.req1_ready, ifa.req0_ready});
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) ifa.req0_valid = 1'b0;
            #1;
            n_tests++;
            if (ifa.req1_ready !== 1'b0) begin
                n_fail++; $display("FAIL tie_hold: T+%0d got req1_ready=%b want 0", c, ifa.req1_ready);
            end
        end
        n_tests++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_p !== 16'd65025 || ifa.rsp_id !== 1'b0) begin
            n_fail++; $display("FAIL tie_rsp0: got v=%b p=%0d id=%b want 1 65025 0", ifa.rsp_valid, ifa.rsp_p, ifa.rsp_id);
        end
        tick();
        #1;
        n_tests++;
        if (ifa.req1_ready !== 1'b1 || ifa.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL tie_second: got req1_ready=%b rv=%b want 1 0", ifa.req1_ready, ifa.rsp_valid);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) ifa.req1_valid = 1'b0;
        end
        #1;
        n_tests++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_p !== 16'd256 || ifa.rsp_id !== 1'b1) begin
            n_fail++; $display("FAIL tie_rsp1: got v=%b p=%0d id=%b want 1 256 1", ifa.rsp_valid, ifa.rsp_p, ifa.rsp_id);
        end
        tick();
        ifa.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        drive_req(0, 1'b1, 8'd7, 8'd9);
        ifa.rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (ifa.req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_accept: got req0_ready=%b want 1", ifa.req0_ready);
        end
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin
                drive_req(0, 1'b1, 8'd2, 8'd2);
                drive_req(1, 1'b1, 8'd3, 8'd3);
            end
            if (c == 9) ifa.rsp_ready = 1'b1;
            #1;
            if (c >= 4) begin
                n_tests++;
                if ({ifa.rsp_valid, busy, ifa.req1_ready, ifa.req0_ready} !== 4'b1100 || ifa.rsp_p !== 16'd63 || ifa.rsp_id !== 1'b0) begin
                    n_fail++; $display("FAIL bp_hold: T+%0d got v=%b busy=%b r1=%b r0=%b p=%0d id=%b want 1 1 0 0 63 0",
                                       c, ifa.rsp_valid, busy, ifa.req1_ready, ifa.req0_ready, ifa.rsp_p, ifa.rsp_id);
                end
            end
        end
        tick();
        drive_req(0, 1'b0, '0, '0);
        drive_req(1, 1'b0, '0, '0);
        ifa.rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (ifa.rsp_valid !== 1'b0 || busy !== 1'b0 || ifa.rsp_p !== 16'd63) begin
            n_fail++; $display("FAIL bp_done: got v=%b busy=%b p=%0d want 0 0 63", ifa.rsp_valid, busy, ifa.rsp_p);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   ng = 0;
        int   last_c = 0;
        int   gid;
        do_reset();
        drive_req(0, 1'b1, W'($urandom), W'($urandom));
        drive_req(1, 1'b1, W'($urandom), W'($urandom));
        ifa.rsp_ready = 1'b1;
        for (int c = 0; c < 60 && (ng < 4 || q.size() != 0); c++) begin
            #1;
            if (ifa.rsp_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got unexpected response p=%0d want none", ifa.rsp_p);
                end else begin
                    e = q.pop_front();
                    if (ifa.rsp_p !== e.p || ifa.rsp_id !== e.id) begin
                        n_fail++; $display("FAIL b2b_rsp: got p=%0d id=%b want %0d %b", ifa.rsp_p, ifa.rsp_id, e.p, e.id);
                    end
                end
            end
            gid = -1;
            if (ifa.req0_ready || ifa.req1_ready) begin
                gid = ifa.req1_ready ? 1 : 0;
                n_tests++;
                if (gid != ng % 2) begin
                    n_fail++; $display("FAIL b2b_order: grant %0d got id %0d want %0d", ng, gid, ng % 2);
                end
                if (ng > 0) begin
                    n_tests++;
                    if (c - last_c != L + 3) begin
                        n_fail++; $display("FAIL b2b_interval: got %0d want %0d", c - last_c, L + 3);
                    end
                end
                e.id = (gid == 1);
                e.p  = gid == 1 ? PW'(ifa.req1_a) * PW'(ifa.req1_b) : PW'(ifa.req0_a) * PW'(ifa.req0_b);
                q.push_back(e);
                last_c = c;
                ng++;
            end
            tick();
            if (gid >= 0) drive_req(gid, ng < 4, W'($urandom), W'($urandom));
        end
        n_tests++;
        if (ng != 4 || q.size() != 0) begin
            n_fail++; $display("FAIL b2b_done: got grants=%0d pending=%0d want 4 0", ng, q.size());
        end
        drive_req(0, 1'b0, '0, '0);
        drive_req(1, 1'b0, '0, '0);
        ifa.rsp_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        drive_req(0, 1'b1, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
        ifa.rsp_ready = 1'b1;
        tick();
        ifa.req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({ifa.rsp_valid, busy} !== 2'b00 || {ifa.mul_a, ifa.mul_b} !== 16'd0 || ifa.rsp_p !== '0) begin
            n_fail++; $display("FAIL rst_mid: got v=%b busy=%b a=%0d b=%0d p=%0d want all 0", ifa.rsp_valid, busy, ifa.mul_a, ifa.mul_b, ifa.rsp_p);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (ifa.rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_dropped: cycle %0d got rsp_valid=%b want 0", c, ifa.rsp_valid);
            end
        end
        drive_req(1, 1'b1, 8'd200, 8'd2);
        #1;
        n_tests++;
        if ({ifa.req1_ready, ifa.req0_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rst_next_ready: got %b want 10", {ifa.req1_ready, ifa.req0_ready});
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) ifa.req1_valid = 1'b0;
        end
        #1;
        n_tests++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_p !== 16'd400 || ifa.rsp_id !== 1'b1) begin
            n_fail++; $display("FAIL rst_next_rsp: got v=%b p=%0d id=%b want 1 400 1", ifa.rsp_valid, ifa.rsp_p, ifa.rsp_id);
        end
        tick();
        ifa.rsp_ready = 1'b0;
    endtask

    // random traffic against a transaction-level model: one outstanding op, response
    // visible 2+L cycles after acceptance, ties go to the requester not served last
    task automatic test_random();
        logic          outst = 1'b0;
        logic          last = 1'b1;
        logic          accp0 = 1'b0;
        logic          accp1 = 1'b0;
        logic          eid = 1'b0;
        logic [PW-1:0] ep = '0;
        int            acc_c = 0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            logic v0, v1, gid, acc, erv;
            if (accp0) ifa.req0_valid = 1'b0;
            if (accp1) ifa.req1_valid = 1'b0;
            accp0 = 1'b0;
            accp1 = 1'b0;
            if (!ifa.req0_valid && $urandom_range(0, 2) == 0) drive_req(0, 1'b1, W'($urandom), W'($urandom));
            else if (ifa.req0_valid && $urandom_range(0, 15) == 0) ifa.req0_valid = 1'b0;
            if (!ifa.req1_valid && $urandom_range(0, 2) == 0) drive_req(1, 1'b1, W'($urandom), W'($urandom));
            else if (ifa.req1_valid && $urandom_range(0, 15) == 0) ifa.req1_valid = 1'b0;
            ifa.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            v0  = ifa.req0_valid;
            v1  = ifa.req1_valid;
            gid = (v0 && v1) ? !last : v1;
            acc = !outst && (v0 || v1);
            erv = outst && (c >= acc_c + 2 + L);
            n_tests++;
            if ({ifa.req1_ready, ifa.req0_ready} !== {acc && gid, acc && !gid}) begin
                n_fail++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, {ifa.req1_ready, ifa.req0_ready}, {acc && gid, acc && !gid});
            end
            n_tests++;
            if (ifa.rsp_valid !== erv) begin
                n_fail++; $display("FAIL rnd_valid: cycle %0d got %b want %b", c, ifa.rsp_valid, erv);
            end
            if (erv) begin
                n_tests++;
                if (ifa.rsp_p !== ep || ifa.rsp_id !== eid) begin
                    n_fail++; $display("FAIL rnd_rsp: cycle %0d got p=%0d id=%b want %0d %b", c, ifa.rsp_p, ifa.rsp_id, ep, eid);
                end
            end
            n_tests++;
            if (busy !== outst) begin
                n_fail++; $display("FAIL rnd_busy: cycle %0d got %b want %b", c, busy, outst);
            end
            if (erv && ifa.rsp_ready) outst = 1'b0;
            if (acc) begin
                outst = 1'b1;
                acc_c = c;
                last  = gid;
                eid   = gid;
                ep    = gid ? PW'(ifa.req1_a) * PW'(ifa.req1_b) : PW'(ifa.req0_a) * PW'(ifa.req0_b);
                if (gid) accp1 = 1'b1;
                else accp0 = 1'b1;
            end
            tick();
        end
        drive_req(0, 1'b0, '0, '0);
        drive_req(1, 1'b0, '0, '0);
        ifa.rsp_ready = 1'b1;
        for (int c = 0; c < 20 && (busy || ifa.rsp_valid); c++) tick();
        ifa.rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || ifa.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain: got busy=%b rv=%b want 0 0", busy, ifa.rsp_valid);
        end
        tick();
    endtask

    task automatic test_lat0();
        logic          ids  [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0]  as   [3] = '{8'd0, 8'd255, 8'd255};
        logic [W-1:0]  bs   [3] = '{8'd200, 8'd1, 8'd255};
        logic [PW-1:0] exps [3] = '{16'd0, 16'd255, 16'd65025};
        for (int k = 0; k < 3; k++) begin
            if (ids[k]) begin
                ifz.req1_valid = 1'b1; ifz.req1_a = as[k]; ifz.req1_b = bs[k];
            end else begin
                ifz.req0_valid = 1'b1; ifz.req0_a = as[k]; ifz.req0_b = bs[k];
            end
            #1;
            n_tests++;
            if ({ifz.req1_ready, ifz.req0_ready} !== (ids[k] ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL lat0_ready%0d: got %b want %b", k, {ifz.req1_ready, ifz.req0_ready}, ids[k] ? 2'b10 : 2'b01);
            end
            tick();
            ifz.req0_valid = 1'b0;
            ifz.req1_valid = 1'b0;
            #1;
            n_tests++;
            if (ifz.rsp_valid !== 1'b0 || busy0 !== 1'b1) begin
                n_fail++; $display("FAIL lat0_wait%0d: got v=%b busy=%b want 0 1", k, ifz.rsp_valid, busy0);
            end
            tick();
            ifz.rsp_ready = 1'b1;
            #1;
            n_tests++;
            if (ifz.rsp_valid !== 1'b1 || ifz.rsp_p !== exps[k] || ifz.rsp_id !== ids[k]) begin
                n_fail++; $display("FAIL lat0_rsp%0d: got v=%b p=%0d id=%b want 1 %0d %b", k, ifz.rsp_valid, ifz.rsp_p, ifz.rsp_id, exps[k], ids[k]);
            end
            tick();
            ifz.rsp_ready = 1'b0;
            #1;
            n_tests++;
            if (ifz.rsp_valid !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++; $display("FAIL lat0_done%0d: got v=%b busy=%b want 0 0", k, ifz.rsp_valid, busy0);
            end
        end
    endtask

    initial begin
        ifz.req0_valid = 1'b0; ifz.req0_a = '0; ifz.req0_b = '0;
        ifz.req1_valid = 1'b0; ifz.req1_a = '0; ifz.req1_b = '0;
        ifz.rsp_ready  = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        test_random();
        test_lat0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish within time limit want finish");
        $fatal(1, "timeout");
    end
endmodule
